// File: rtl/usb_tx_if.sv
// Bundle of request, FIFO and line signals between the protocol controller and usb_tx.
// The master modport drives requests and FIFO data; the slave modport is the transmitter.
interface usb_tx_if;
   logic [2:0] tx_packet;
   logic [6:0] buffer_occupancy;
   logic [7:0] tx_packet_data;
   logic       get_tx_packet_data;
   logic       tx_transfer_active;
   logic       tx_error;
   logic       d_plus;
   logic       d_minus;

   modport master (
      output tx_packet, buffer_occupancy, tx_packet_data,
      input  get_tx_packet_data, tx_transfer_active, tx_error, d_plus, d_minus
   );

   modport slave (
      input  tx_packet, buffer_occupancy, tx_packet_data,
      output get_tx_packet_data, tx_transfer_active, tx_error, d_plus, d_minus
   );
endinterface

// File: rtl/usb_tx.sv
// USB full-speed transmitter: SYNC, PID, optional DATA0 payload + CRC16, NRZI, bit stuffing, EOP.
// Latency: first SYNC bit on the clock after the request is sampled; every bit lasts CLKS_PER_BIT clocks.
// Backpressure: none; FIFO head is popped once per payload byte. Macro USB_TX_ERR_CHK_EN enables tx_error.
module usb_tx #(
   parameter int CLKS_PER_BIT = 8,
   parameter int MAX_PAYLOAD  = 64
) (
   input  logic   clk,
   input  logic   n_rst,
   usb_tx_if.slave bus
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] SYNC    = 3'd1;
   localparam logic [2:0] PID     = 3'd2;
   localparam logic [2:0] PAYLOAD = 3'd3;
   localparam logic [2:0] CRC     = 3'd4;
   localparam logic [2:0] EOP     = 3'd5;

   localparam logic [7:0] SYNC_BYTE = 8'h80;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [2:0]    ones_q, ones_d;
   logic [7:0]    byte_q, byte_d;
   logic [7:0]    pid_q, pid_d;
   logic          data0_q, data0_d;
   logic [6:0]    count_q, count_d;
   logic [15:0]   crc_q, crc_d;
   logic          line_q, line_d;
   logic          se0_q, se0_d;
   logic          get_q, get_d;

   logic       dbit, send, upd_crc, load;
   logic [3:0] nbit;

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      ones_d    = ones_q;
      byte_d    = byte_q;
      pid_d     = pid_q;
      data0_d   = data0_q;
      count_d   = count_q;
      crc_d     = crc_q;
      line_d    = line_q;
      se0_d     = se0_q;
      get_d     = 1'b0;
      dbit      = 1'b0;
      send      = 1'b0;
      upd_crc   = 1'b0;
      load      = 1'b0;
      nbit      = bit_cnt_q + 4'd1;

      if (state_q == IDLE) begin
         if (bus.tx_packet >= 3'd1 && bus.tx_packet <= 3'd4) begin
            state_d   = SYNC;
            clk_cnt_d = '0;
            bit_cnt_d = 4'd0;
            ones_d    = 3'd0;
            line_d    = ~line_q;
            se0_d     = 1'b0;
            crc_d     = 16'hFFFF;
            data0_d   = (bus.tx_packet == 3'd1);
            count_d   = 7'd0;
            case (bus.tx_packet)
               3'd1: begin
                  pid_d   = 8'hC3;
                  count_d = (bus.buffer_occupancy > 7'(MAX_PAYLOAD)) ? 7'(MAX_PAYLOAD)
                                                                     : bus.buffer_occupancy;
               end
               3'd2:    pid_d = 8'hD2;
               3'd3:    pid_d = 8'h5A;
               default: pid_d = 8'h1E;
            endcase
         end
      end else if (clk_cnt_q != CLK_LAST) begin
         clk_cnt_d = clk_cnt_q + 1'b1;
      end else begin
         clk_cnt_d = '0;
         // A stuffed zero holds the field position so CRC and byte counting never see it.
         if (state_q != EOP && ones_q == 3'd6) begin
            send = 1'b1;
            dbit = 1'b0;
         end else begin
            case (state_q)
               SYNC: begin
                  send = 1'b1;
                  if (bit_cnt_q != 4'd7) begin
                     bit_cnt_d = nbit;
                     dbit      = SYNC_BYTE[nbit[2:0]];
                  end else begin
                     state_d   = PID;
                     bit_cnt_d = 4'd0;
                     dbit      = pid_q[0];
                  end
               end
               PID: begin
                  send = 1'b1;
                  if (bit_cnt_q != 4'd7) begin
                     bit_cnt_d = nbit;
                     dbit      = pid_q[nbit[2:0]];
                  end else if (!data0_q) begin
                     state_d   = EOP;
                     bit_cnt_d = 4'd0;
                     send      = 1'b0;
                  end else if (count_q != 7'd0) begin
                     load = 1'b1;
                  end else begin
                     state_d   = CRC;
                     bit_cnt_d = 4'd0;
                     dbit      = ~crc_q[15];
                  end
               end
               PAYLOAD: begin
                  send = 1'b1;
                  if (bit_cnt_q != 4'd7) begin
                     bit_cnt_d = nbit;
                     dbit      = byte_q[nbit[2:0]];
                     upd_crc   = 1'b1;
                  end else if (count_q != 7'd0) begin
                     load = 1'b1;
                  end else begin
                     state_d   = CRC;
                     bit_cnt_d = 4'd0;
                     dbit      = ~crc_q[15];
                  end
               end
               CRC: begin
                  send = 1'b1;
                  if (bit_cnt_q != 4'd15) begin
                     bit_cnt_d = nbit;
                     dbit      = ~crc_q[4'd15 - nbit];
                  end else begin
                     state_d   = EOP;
                     bit_cnt_d = 4'd0;
                     send      = 1'b0;
                  end
               end
               EOP: begin
                  if (bit_cnt_q != 4'd2) bit_cnt_d = nbit;
                  else                   state_d   = IDLE;
               end
               default: state_d = IDLE;
            endcase
         end

         // Head byte is captured as its first bit goes out; the pop lands at the end of that clock.
         if (load) begin
            state_d   = PAYLOAD;
            bit_cnt_d = 4'd0;
            byte_d    = bus.tx_packet_data;
            count_d   = count_q - 7'd1;
            get_d     = 1'b1;
            dbit      = bus.tx_packet_data[0];
            upd_crc   = 1'b1;
         end

         if (send) begin
            line_d = dbit ? line_q : ~line_q;
            ones_d = dbit ? ones_q + 3'd1 : 3'd0;
            se0_d  = 1'b0;
         end
         if (state_d == EOP) begin
            se0_d  = (bit_cnt_d != 4'd2);
            line_d = 1'b1;
         end
         if (upd_crc) begin
            crc_d = {crc_q[14:0], 1'b0} ^ ((dbit ^ crc_q[15]) ? 16'h8005 : 16'h0000);
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= 4'd0;
         ones_q    <= 3'd0;
         byte_q    <= 8'h00;
         pid_q     <= 8'h00;
         data0_q   <= 1'b0;
         count_q   <= 7'd0;
         crc_q     <= 16'hFFFF;
         line_q    <= 1'b1;
         se0_q     <= 1'b0;
         get_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         ones_q    <= ones_d;
         byte_q    <= byte_d;
         pid_q     <= pid_d;
         data0_q   <= data0_d;
         count_q   <= count_d;
         crc_q     <= crc_d;
         line_q    <= line_d;
         se0_q     <= se0_d;
         get_q     <= get_d;
      end
   end

   assign bus.d_plus             = ~se0_q & line_q;
   assign bus.d_minus            = ~se0_q & ~line_q;
   assign bus.get_tx_packet_data = get_q;
   assign bus.tx_transfer_active = (state_q != IDLE);

`ifdef USB_TX_ERR_CHK_EN
   logic err_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) err_q <= 1'b0;
      else        err_q <= (state_q == IDLE) ? (bus.tx_packet > 3'd4) : (bus.tx_packet != 3'd0);
   end

   assign bus.tx_error = err_q;
`else
   assign bus.tx_error = 1'b0;
`endif
endmodule

// File: tb/tb_usb_tx.sv
// Directed bench for usb_tx: vector table of packet requests plus reset, invalid-code and abort sequences.
module tb_usb_tx;
   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   usb_tx_if bus();
   usb_tx #(.CLKS_PER_BIT(8), .MAX_PAYLOAD(64)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

`ifdef USB_TX_ERR_CHK_EN
   localparam int ERR_ON = 1;
`else
   localparam int ERR_ON = 0;
`endif

   typedef struct {
      logic [2:0] code;
      logic [6:0] occ;
      logic [7:0] dat;
      bit         noise;
      int         exp_clks;
      int         exp_gets;
   } vec_t;

   vec_t       vecs[8];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [1:0] exp_sym[$];
   int         exp_get[$];
   logic       rec_dp[$];
   int         first_get;
   logic       m_line;
   int         m_ones;
   logic [15:0] m_crc;
   bit         ack_dp[19];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic m_push(input logic b, input logic mark);
      if (mark) exp_get.push_back(exp_sym.size() * 8);
      if (!b) m_line = ~m_line;
      exp_sym.push_back({m_line, ~m_line});
      if (b) m_ones++;
      else   m_ones = 0;
      if (m_ones == 6) begin
         m_line = ~m_line;
         exp_sym.push_back({m_line, ~m_line});
         m_ones = 0;
      end
   endtask

   task automatic m_byte(input logic [7:0] v, input logic is_pay);
      logic fb;
      for (int i = 0; i < 8; i++) begin
         if (is_pay) begin
            fb    = v[i] ^ m_crc[15];
            m_crc = {m_crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
         end
         m_push(v[i], is_pay && (i == 0));
      end
   endtask

   task automatic build(input logic [2:0] code, input logic [6:0] occ, input logic [7:0] dat);
      logic [7:0] pid;
      int n;
      exp_sym.delete();
      exp_get.delete();
      m_line = 1'b1;
      m_ones = 0;
      m_crc  = 16'hFFFF;
      case (code)
         3'd1:    pid = 8'hC3;
         3'd2:    pid = 8'hD2;
         3'd3:    pid = 8'h5A;
         default: pid = 8'h1E;
      endcase
      m_byte(8'h80, 1'b0);
      m_byte(pid, 1'b0);
      if (code == 3'd1) begin
         n = (occ > 7'd64) ? 64 : int'(occ);
         for (int i = 0; i < n; i++) m_byte(dat + 8'(i), 1'b1);
         for (int i = 15; i >= 0; i--) m_push(~m_crc[i], 1'b0);
      end
      exp_sym.push_back(2'b00);
      exp_sym.push_back(2'b00);
      exp_sym.push_back(2'b10);
   endtask

   // Starts and ends on a falling edge so the next request can follow back to back.
   task automatic run_vec(input int idx, input logic [2:0] code, input logic [6:0] occ,
                          input logic [7:0] dat, input bit noise, input int exp_clks_in,
                          input int exp_gets);
      string nm;
      int clks, gets, errs, bad_line, bad_get, exp_clks;
      logic [1:0] sym;
      nm = $sformatf("vec%0d", idx);
      build(code, occ, dat);
      exp_clks = (exp_clks_in == 0) ? exp_sym.size() * 8 : exp_clks_in;
      bus.tx_packet        = code;
      bus.buffer_occupancy = occ;
      bus.tx_packet_data   = dat;
      @(posedge clk);
      @(negedge clk);
      bus.tx_packet = 3'd0;
      clks = 0; gets = 0; errs = 0; bad_line = 0; bad_get = 0; first_get = -1;
      rec_dp.delete();
      for (int c = 0; c < 6000; c++) begin
         if (!bus.tx_transfer_active) break;
         if (noise && c == 20) bus.tx_packet = 3'd4;
         if (noise && c == 40) bus.tx_packet = 3'd0;
         rec_dp.push_back(bus.d_plus);
         sym = ((c / 8) < exp_sym.size()) ? exp_sym[c / 8] : 2'b11;
         if ({bus.d_plus, bus.d_minus} != sym) bad_line++;
         if (bus.get_tx_packet_data) begin
            if (first_get < 0) first_get = c;
            if (gets >= exp_get.size()) bad_get++;
            else if (exp_get[gets] != c) bad_get++;
            gets++;
            bus.tx_packet_data = bus.tx_packet_data + 8'd1;
         end
         if (bus.tx_error) errs++;
         clks++;
         @(negedge clk);
      end
      check({nm, " active_clks"}, clks, exp_clks);
      check({nm, " get_pulses"}, gets, exp_gets);
      check({nm, " line_bad_clks"}, bad_line, 0);
      check({nm, " get_position_bad"}, bad_get, 0);
      check({nm, " tx_error_pulses"}, errs, noise ? 20 * ERR_ON : 0);
      check({nm, " idle_after"}, {bus.d_plus, bus.d_minus}, 2'b10);
   endtask

   initial begin
      int bad, errs;
      n_rst                = 1'b0;
      bus.tx_packet        = 3'd0;
      bus.buffer_occupancy = 7'd0;
      bus.tx_packet_data   = 8'h00;
      ack_dp = '{0,1,0,1,0,1,0,0, 1,1,0,1,1,0,0,0, 0,0,1};

      vecs[0] = '{3'd2, 7'd0,  8'h00, 1'b0, 152, 0};
      vecs[1] = '{3'd3, 7'd5,  8'h00, 1'b0, 152, 0};
      vecs[2] = '{3'd4, 7'd0,  8'h00, 1'b1, 152, 0};
      vecs[3] = '{3'd1, 7'd0,  8'h00, 1'b0, 280, 0};
      vecs[4] = '{3'd1, 7'd1,  8'hFF, 1'b0, 360, 1};
      vecs[5] = '{3'd1, 7'd3,  8'h7E, 1'b0, 0,   3};
      vecs[6] = '{3'd1, 7'd70, 8'h00, 1'b0, 0,   64};
      vecs[7] = '{3'd1, 7'd64, 8'hC0, 1'b0, 0,   64};

      repeat (3) @(negedge clk);
      check("rst d_plus", bus.d_plus, 1);
      check("rst d_minus", bus.d_minus, 0);
      check("rst active", bus.tx_transfer_active, 0);
      check("rst get", bus.get_tx_packet_data, 0);
      check("rst tx_error", bus.tx_error, 0);

      n_rst = 1'b1;
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (bus.d_plus !== 1'b1 || bus.d_minus !== 1'b0 || bus.tx_transfer_active !== 1'b0 ||
             bus.get_tx_packet_data !== 1'b0) bad++;
      end
      check("idle_hold_bad_clks", bad, 0);

      for (int i = 0; i < 8; i++) begin
         run_vec(i, vecs[i].code, vecs[i].occ, vecs[i].dat, vecs[i].noise,
                 vecs[i].exp_clks, vecs[i].exp_gets);
         if (i == 0) begin
            bad = 0;
            if (rec_dp.size() < 152) bad = 19;
            else for (int k = 0; k < 19; k++) if (rec_dp[8 * k + 4] != ack_dp[k]) bad++;
            check("ack_dplus_bits_bad", bad, 0);
         end
         if (i == 4) check("ff_first_get_clk", first_get, 128);
      end

      errs = 0; bad = 0;
      for (int code = 5; code < 8; code++) begin
         bus.tx_packet = 3'(code);
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) bus.tx_packet = 3'd0;
            if (bus.tx_error) errs++;
            if (bus.tx_transfer_active || !bus.d_plus || bus.d_minus) bad++;
         end
      end
      check("invalid tx_error_pulses", errs, 3 * ERR_ON);
      check("invalid bus_not_idle", bad, 0);

      bus.tx_packet        = 3'd1;
      bus.buffer_occupancy = 7'd4;
      bus.tx_packet_data   = 8'h33;
      @(posedge clk);
      @(negedge clk);
      bus.tx_packet = 3'd0;
      repeat (140) @(negedge clk);
      check("abort active_before", bus.tx_transfer_active, 1);
      #2 n_rst = 1'b0;
      #1;
      check("abort d_plus", bus.d_plus, 1);
      check("abort d_minus", bus.d_minus, 0);
      check("abort active", bus.tx_transfer_active, 0);
      check("abort get", bus.get_tx_packet_data, 0);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      run_vec(8, 3'd2, 7'd0, 8'h00, 1'b0, 152, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
